autoconfig_master: RTL

Hardware Zorro II autoconfig initiator, the host-side counterpart of our card's autoconfig responder. On `start` it drives `_configout` low to the first board in the chain and reads the board's autoconfig nibbles at $E8xxxx. It then assigns a size-aligned base address from a free-memory pool, or shuts the board up. It repeats for each board in the chain until a read times out. Used for bench bring-up and bus-master/accelerator boards that must configure the chain without the Amiga ROM.

---
 rtl/autoconfig_master.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/autoconfig_master.sv
// Zorro II autoconfig initiator: reads each board's nibbles at $E8xxxx, assigns a size-aligned base or shuts it up.
// Each access is ADDR, STRB (up to TIMEOUT cycles waiting on DTACK), RCVR; the bus slave throttles via DTACK.
module autoconfig_master #(
  parameter int          TIMEOUT    = 15,
  parameter logic [7:0]  BASE_START = 8'h20,
  parameter logic [8:0]  MEM_TOP    = 9'h0A0,
  parameter int          MAX_BOARDS = 8
) (
  input  logic        CLK,
  input  logic        _RST,
  input  logic        start,
  output logic [7:0]  AH,
  output logic [5:0]  AL,
  output logic        RW,
  output logic        _UDS,
  input  logic [3:0]  D_i,
  output logic [3:0]  D_o,
  output logic        D_oe,
  input  logic        DTACK,
  output logic        _configout,
  output logic        busy,
  output logic        done,
  output logic        board_valid,
  output logic [7:0]  board_type,
  output logic [7:0]  board_product,
  output logic [7:0]  board_flags,
  output logic [15:0] board_mfg,
  output logic [7:0]  board_base,
  output logic        board_shutup,
  output logic        board_err,
  output logic [3:0]  board_count
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_STRB, S_RCVR, S_ALLOC, S_REPORT, S_DONE
  } state_t;

  state_t         state, state_nx;
  logic [3:0]     rd_idx;
  logic           writing;
  logic           wr_last;
  logic [TW-1:0]  tcnt;
  logic           tmo;
  logic [39:0]    nib;
  logic [8:0]     next_free;

  logic           timed_out;
  logic [2:0]     sz;
  logic [8:0]     units;
  logic [8:0]     base_al;
  logic [9:0]     base_end;
  logic           alloc_err;

  // Read order skips $0C/$0E: word indices 0-5 then 8-11.
  function automatic logic [5:0] word_idx(input logic [3:0] i);
    return (i < 4'd6) ? {2'b00, i} : ({2'b00, i} + 6'd2);
  endfunction

  assign AH        = 8'hE8;
  assign timed_out = (tcnt == TW'(TIMEOUT - 1)) && !DTACK;

  always_comb begin
    sz        = nib[34:32];
    units     = (sz == 3'd0) ? 9'd128 : (9'd1 << (sz - 3'd1));
    base_al   = (next_free + units - 9'd1) & ~(units - 9'd1);
    base_end  = {1'b0, base_al} + {1'b0, units};
    alloc_err = (nib[39:38] != 2'b11) || (base_end > {1'b0, MEM_TOP});
  end

  always_ff @(posedge CLK) begin
    if (!_RST) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    _UDS        = 1'b1;
    D_oe        = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    board_valid = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nx = S_ADDR;
      end
      S_ADDR: state_nx = S_STRB;
      S_STRB: begin
        _UDS = 1'b0;
        D_oe = !RW;
        if (DTACK || timed_out) state_nx = S_RCVR;
      end
      S_RCVR: begin
        if (writing)            state_nx = wr_last ? S_REPORT : S_ADDR;
        else if (tmo)           state_nx = (rd_idx == 4'd0) ? S_DONE : S_REPORT;
        else if (rd_idx == 4'd9) state_nx = S_ALLOC;
        else                    state_nx = S_ADDR;
      end
      S_ALLOC: state_nx = S_ADDR;
      S_REPORT: begin
        board_valid = 1'b1;
        state_nx = (board_count == 4'(MAX_BOARDS - 1)) ? S_DONE : S_ADDR;
      end
      S_DONE: begin
        busy     = 1'b0;
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign _configout = !busy;

  always_ff @(posedge CLK) begin
    if (!_RST) begin
      AL            <= '0;
      RW            <= 1'b1;
      D_o           <= '0;
      rd_idx        <= '0;
      writing       <= 1'b0;
      wr_last       <= 1'b0;
      tcnt          <= '0;
      tmo           <= 1'b0;
      nib           <= '0;
      next_free     <= {1'b0, BASE_START};
      board_type    <= '0;
      board_product <= '0;
      board_flags   <= '0;
      board_mfg     <= '0;
      board_base    <= '0;
      board_shutup  <= 1'b0;
      board_err     <= 1'b0;
      board_count   <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          board_count  <= '0;
          board_err    <= 1'b0;
          board_shutup <= 1'b0;
          board_base   <= '0;
          rd_idx       <= '0;
          writing      <= 1'b0;
          wr_last      <= 1'b0;
          AL           <= '0;
          RW           <= 1'b1;
          D_o          <= '0;
        end
        S_ADDR: begin
          tcnt <= '0;
          tmo  <= 1'b0;
        end
        S_STRB: begin
          tcnt <= tcnt + 1'b1;
          if (DTACK) begin
            if (RW) nib <= {nib[35:0], D_i};
          end else if (timed_out) begin
            tmo <= 1'b1;
          end
        end
        S_RCVR: begin
          if (writing) begin
            if (tmo) board_err <= 1'b1;
            if (!wr_last) begin
              AL      <= 6'h24;
              D_o     <= board_base[7:4];
              wr_last <= 1'b1;
            end
          end else if (tmo) begin
            if (rd_idx != 4'd0) board_err <= 1'b1;
          end else if (rd_idx != 4'd9) begin
            rd_idx <= rd_idx + 4'd1;
            AL     <= word_idx(rd_idx + 4'd1);
          end
        end
        S_ALLOC: begin
          board_type    <= nib[39:32];
          board_product <= ~nib[31:24];
          board_flags   <= ~nib[23:16];
          board_mfg     <= ~nib[15:0];
          writing       <= 1'b1;
          RW            <= 1'b0;
          if (alloc_err) begin
            board_err    <= 1'b1;
            board_shutup <= 1'b1;
            board_base   <= '0;
            AL           <= 6'h26;
            D_o          <= '0;
            wr_last      <= 1'b1;
          end else begin
            board_base <= base_al[7:0];
            next_free  <= base_end[8:0];
            AL         <= 6'h25;
            D_o        <= base_al[3:0];
            wr_last    <= 1'b0;
          end
        end
        S_REPORT: begin
          // Prepare the $00 read of the next board in the chain.
          board_count  <= board_count + 4'd1;
          rd_idx       <= '0;
          writing      <= 1'b0;
          wr_last      <= 1'b0;
          AL           <= '0;
          RW           <= 1'b1;
          D_o          <= '0;
          board_err    <= 1'b0;
          board_shutup <= 1'b0;
          board_base   <= '0;
        end
        S_DONE: begin
          RW      <= 1'b1;
          D_o     <= '0;
          writing <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
